// File: rtl/multicycle_control_pkg.sv
// Shared types for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU operation codes, datapath mux selects and the bundled control word.
package multicycle_control_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_XORI  = 6'h0E,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_type;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_IEXEC,
        S_IWB,
        S_BEQ,
        S_BNE,
        S_JUMP,
        S_JAL,
        S_JR,
        S_ILLEGAL
    } ctrl_state_t;

    localparam int ALU_OP_BITS = 3;
    localparam logic [ALU_OP_BITS-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_FUNCT = 3'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLT   = 3'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR   = 3'd4;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;

    localparam logic [1:0] ALUB_B      = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    typedef struct packed {
        logic                   pc_write;
        logic                   pc_write_beq;
        logic                   pc_write_bne;
        logic                   iord;
        logic                   mem_read;
        logic                   mem_write;
        logic                   ir_write;
        logic [1:0]             reg_dst;
        logic [1:0]             mem_to_reg;
        logic                   reg_write;
        logic                   alu_src_a;
        logic [1:0]             alu_src_b;
        logic [ALU_OP_BITS-1:0] alu_op;
        logic [1:0]             pc_src;
        logic                   illegal;
    } ctrl_out_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in,
// enables and mux selects out.
interface multicycle_control_if #(
    parameter int ALUOP_W = 3
) ();
    import multicycle_control_pkg::*;

    opcode_type          op;
    logic [5:0]          funct;
    logic                mem_ready;

    logic                pc_write;
    logic                pc_write_beq;
    logic                pc_write_bne;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic [1:0]          reg_dst;
    logic [1:0]          mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_src;
    logic                illegal;
    ctrl_state_t         state_o;

    modport master (
        input  op, funct, mem_ready,
        output pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal, state_o
    );

    modport slave (
        output op, funct, mem_ready,
        input  pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_src, illegal, state_o
    );

endinterface

// File: rtl/multicycle_control_ctrl_output_decode.sv
// Moore map from FSM state to the datapath control word; FETCH's IR/PC
// loads are the only outputs qualified by the memory handshake.
module ctrl_output_decode
    import multicycle_control_pkg::*;
(
    input  ctrl_state_t i_state,
    input  opcode_type  i_op,
    input  logic        i_mem_ready,
    output ctrl_out_t   o_ctrl
);

    always_comb begin
        // NOTE: default the whole word first so no path through the case infers a latch.
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALUB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = ALUB_IMM_SH;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REG_DST_RT;
                o_ctrl.mem_to_reg = MTR_MDR;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_RTEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_B;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REG_DST_RD;
                o_ctrl.mem_to_reg = MTR_ALUOUT;
            end
            S_IEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
                case (i_op)
                    OP_SLTI: o_ctrl.alu_op = ALU_SLT;
                    OP_XORI: o_ctrl.alu_op = ALU_XOR;
                    default: o_ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_IWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REG_DST_RT;
                o_ctrl.mem_to_reg = MTR_ALUOUT;
            end
            S_BEQ, S_BNE: begin
                o_ctrl.alu_src_a    = 1'b1;
                o_ctrl.alu_src_b    = ALUB_B;
                o_ctrl.alu_op       = ALU_SUB;
                o_ctrl.pc_src       = PCSRC_ALUOUT;
                o_ctrl.pc_write_beq = (i_state == S_BEQ);
                o_ctrl.pc_write_bne = (i_state == S_BNE);
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC was already advanced in FETCH, so it is the link value.
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_src     = PCSRC_JUMP;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = REG_DST_RA;
                o_ctrl.mem_to_reg = MTR_PC;
            end
            S_JR: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_REG;
            end
            S_ILLEGAL: o_ctrl.illegal = 1'b1;
            default:   o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: holds state and the opcode latched at DECODE,
// and drives the datapath through ctrl_output_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W         = 3,
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master io_bus
);

    ctrl_state_t r_state;
    opcode_type  r_op;
    logic        w_ready;
    ctrl_out_t   w_ctrl;
    ctrl_out_t   w_ctrl_gated;

    assign w_ready = !MEM_WAIT_EN || io_bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= OP_RTYPE;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            case (r_state)
                S_FETCH:  if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= io_bus.op;
                    case (io_bus.op)
                        OP_LW, OP_SW:              r_state <= S_MEMADR;
                        OP_RTYPE:                  r_state <= (io_bus.funct == FUNCT_JR) ? S_JR : S_RTEXEC;
                        OP_ADDI, OP_SLTI, OP_XORI: r_state <= S_IEXEC;
                        OP_BEQ:                    r_state <= S_BEQ;
                        OP_BNE:                    r_state <= S_BNE;
                        OP_J:                      r_state <= S_JUMP;
                        OP_JAL:                    r_state <= S_JAL;
                        default:                   r_state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:  r_state <= (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (w_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (w_ready) r_state <= S_FETCH;
                S_RTEXEC:  r_state <= S_RTWB;
                S_IEXEC:   r_state <= S_IWB;
                S_ILLEGAL: if (!HALT_ON_ILLEGAL) r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .i_state     (r_state),
        .i_op        (r_op),
        .i_mem_ready (w_ready),
        .o_ctrl      (w_ctrl)
    );

    // Reset kills requests combinationally so an in-flight access drops at once.
    assign w_ctrl_gated = rst_n ? w_ctrl : '0;

    assign io_bus.pc_write     = w_ctrl_gated.pc_write;
    assign io_bus.pc_write_beq = w_ctrl_gated.pc_write_beq;
    assign io_bus.pc_write_bne = w_ctrl_gated.pc_write_bne;
    assign io_bus.iord         = w_ctrl_gated.iord;
    assign io_bus.mem_read     = w_ctrl_gated.mem_read;
    assign io_bus.mem_write    = w_ctrl_gated.mem_write;
    assign io_bus.ir_write     = w_ctrl_gated.ir_write;
    assign io_bus.reg_dst      = w_ctrl_gated.reg_dst;
    assign io_bus.mem_to_reg   = w_ctrl_gated.mem_to_reg;
    assign io_bus.reg_write    = w_ctrl_gated.reg_write;
    assign io_bus.alu_src_a    = w_ctrl_gated.alu_src_a;
    assign io_bus.alu_src_b    = w_ctrl_gated.alu_src_b;
    assign io_bus.alu_op       = ALUOP_W'(w_ctrl_gated.alu_op);
    assign io_bus.pc_src       = w_ctrl_gated.pc_src;
    assign io_bus.illegal      = w_ctrl_gated.illegal;
    assign io_bus.state_o      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction expands into its expected
// per-cycle sequence (state, control word, mem_ready to drive) and is replayed.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct {
        logic        rdy;
        opcode_type  op;
        logic [5:0]  fn;
        ctrl_state_t st;
        ctrl_out_t   out;
    } rec_t;
    typedef rec_t rec_q_t[$];

    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control_if #(.ALUOP_W(3)) bus_a ();
    multicycle_control_if #(.ALUOP_W(3)) bus_b ();

    // A: wait states honoured, illegal is sticky. B: single-cycle memory, illegal recovers.
    multicycle_control #(.ALUOP_W(3), .MEM_WAIT_EN(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .io_bus(bus_a)
    );
    multicycle_control #(.ALUOP_W(3), .MEM_WAIT_EN(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .io_bus(bus_b)
    );

    ctrl_out_t got_a;
    ctrl_out_t got_b;
    assign got_a = {bus_a.pc_write, bus_a.pc_write_beq, bus_a.pc_write_bne, bus_a.iord,
                    bus_a.mem_read, bus_a.mem_write, bus_a.ir_write, bus_a.reg_dst,
                    bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b,
                    bus_a.alu_op, bus_a.pc_src, bus_a.illegal};
    assign got_b = {bus_b.pc_write, bus_b.pc_write_beq, bus_b.pc_write_bne, bus_b.iord,
                    bus_b.mem_read, bus_b.mem_write, bus_b.ir_write, bus_b.reg_dst,
                    bus_b.mem_to_reg, bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b,
                    bus_b.alu_op, bus_b.pc_src, bus_b.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input ctrl_state_t st, input opcode_type op, input logic [5:0] fn);
        rec_t e;
        e.rdy = 1'($urandom_range(0, 1));
        e.op  = op;
        e.fn  = fn;
        e.st  = st;
        e.out = '0;
        return e;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction. After DECODE the
    // IR is scrambled, so anything depending on the opcode must use the latched copy.
    function automatic rec_q_t build(input bit wait_en, input opcode_type op, input logic [5:0] fn,
                                     input int fw, input int mw, input int ill_len);
        rec_q_t     r;
        rec_t       e;
        int         nfw = wait_en ? fw : 0;
        int         nmw = wait_en ? mw : 0;
        opcode_type jop = opcode_type'(6'($urandom_range(0, 63)));
        logic [5:0] jfn = 6'($urandom_range(0, 63));
        for (int i = 0; i <= nfw; i++) begin
            e = mk(S_FETCH, op, fn);
            if (wait_en) e.rdy = (i == nfw);
            e.out.mem_read  = 1'b1;
            e.out.alu_src_b = ALUB_FOUR;
            e.out.ir_write  = (i == nfw);
            e.out.pc_write  = (i == nfw);
            r.push_back(e);
        end
        e = mk(S_DECODE, op, fn);
        e.out.alu_src_b = ALUB_IMM_SH;
        r.push_back(e);
        case (op)
            OP_LW, OP_SW: begin
                e = mk(S_MEMADR, jop, jfn);
                e.out.alu_src_a = 1'b1;
                e.out.alu_src_b = ALUB_IMM;
                r.push_back(e);
                for (int i = 0; i <= nmw; i++) begin
                    e = mk((op == OP_LW) ? S_MEMRD : S_MEMWR, jop, jfn);
                    if (wait_en) e.rdy = (i == nmw);
                    e.out.iord      = 1'b1;
                    e.out.mem_read  = (op == OP_LW);
                    e.out.mem_write = (op == OP_SW);
                    r.push_back(e);
                end
                if (op == OP_LW) begin
                    e = mk(S_MEMWB, jop, jfn);
                    e.out.reg_write  = 1'b1;
                    e.out.mem_to_reg = MTR_MDR;
                    r.push_back(e);
                end
            end
            OP_RTYPE: begin
                if (fn == FUNCT_JR) begin
                    e = mk(S_JR, jop, jfn);
                    e.out.pc_write = 1'b1;
                    e.out.pc_src   = PCSRC_REG;
                    r.push_back(e);
                end else begin
                    e = mk(S_RTEXEC, jop, jfn);
                    e.out.alu_src_a = 1'b1;
                    e.out.alu_op    = ALU_FUNCT;
                    r.push_back(e);
                    e = mk(S_RTWB, jop, jfn);
                    e.out.reg_write = 1'b1;
                    e.out.reg_dst   = REG_DST_RD;
                    r.push_back(e);
                end
            end
            OP_ADDI, OP_SLTI, OP_XORI: begin
                e = mk(S_IEXEC, jop, jfn);
                e.out.alu_src_a = 1'b1;
                e.out.alu_src_b = ALUB_IMM;
                e.out.alu_op    = (op == OP_SLTI) ? ALU_SLT : (op == OP_XORI) ? ALU_XOR : ALU_ADD;
                r.push_back(e);
                e = mk(S_IWB, jop, jfn);
                e.out.reg_write = 1'b1;
                r.push_back(e);
            end
            OP_BEQ, OP_BNE: begin
                e = mk((op == OP_BEQ) ? S_BEQ : S_BNE, jop, jfn);
                e.out.alu_src_a    = 1'b1;
                e.out.alu_op       = ALU_SUB;
                e.out.pc_src       = PCSRC_ALUOUT;
                e.out.pc_write_beq = (op == OP_BEQ);
                e.out.pc_write_bne = (op == OP_BNE);
                r.push_back(e);
            end
            OP_J, OP_JAL: begin
                e = mk((op == OP_J) ? S_JUMP : S_JAL, jop, jfn);
                e.out.pc_write = 1'b1;
                e.out.pc_src   = PCSRC_JUMP;
                if (op == OP_JAL) begin
                    e.out.reg_write  = 1'b1;
                    e.out.reg_dst    = REG_DST_RA;
                    e.out.mem_to_reg = MTR_PC;
                end
                r.push_back(e);
            end
            default: begin
                for (int i = 0; i < ill_len; i++) begin
                    e = mk(S_ILLEGAL, jop, jfn);
                    e.out.illegal = 1'b1;
                    r.push_back(e);
                end
            end
        endcase
        return r;
    endfunction

    function automatic opcode_type pick_op(input bit allow_illegal);
        opcode_type legal [10];
        legal = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_XORI, OP_LW, OP_SW};
        if (allow_illegal && ($urandom_range(0, 7) == 0))
            return opcode_type'(6'($urandom_range(0, 63)));
        return legal[$urandom_range(0, 9)];
    endfunction

    function automatic logic [5:0] pick_fn();
        if ($urandom_range(0, 3) == 0) return FUNCT_JR;
        return 6'($urandom_range(0, 63));
    endfunction

    // Drive one cycle's inputs on the falling edge, compare just after it.
    task automatic apply(input int dut, input rec_t e, input string tag);
        @(negedge clk);
        if (dut == 0) begin
            rst_a_n         = 1'b1;
            bus_a.op        = e.op;
            bus_a.funct     = e.fn;
            bus_a.mem_ready = e.rdy;
            #1;
            check({tag, " state"}, 32'(bus_a.state_o), 32'(e.st));
            check({tag, " outputs"}, 32'(got_a), 32'(e.out));
        end else begin
            rst_b_n         = 1'b1;
            bus_b.op        = e.op;
            bus_b.funct     = e.fn;
            bus_b.mem_ready = e.rdy;
            #1;
            check({tag, " state"}, 32'(bus_b.state_o), 32'(e.st));
            check({tag, " outputs"}, 32'(got_b), 32'(e.out));
        end
    endtask

    task automatic run_q(input int dut, input rec_q_t q, input string tag);
        foreach (q[i]) apply(dut, q[i], tag);
    endtask

    task automatic reset_check(input int dut, input string tag);
        if (dut == 0) begin
            check({tag, " state"}, 32'(bus_a.state_o), 32'(S_FETCH));
            check({tag, " outputs"}, 32'(got_a), 32'h0);
        end else begin
            check({tag, " state"}, 32'(bus_b.state_o), 32'(S_FETCH));
            check({tag, " outputs"}, 32'(got_b), 32'h0);
        end
    endtask

    task automatic proc_a();
        rec_q_t q;
        rst_a_n         = 1'b0;
        bus_a.op        = OP_RTYPE;
        bus_a.funct     = 6'h0;
        bus_a.mem_ready = 1'b1;
        @(negedge clk);
        #1 reset_check(0, "a_reset");
        for (int n = 0; n < 60; n++)
            run_q(0, build(1'b1, pick_op(1'b0), pick_fn(), $urandom_range(0, 3), $urandom_range(0, 3), 1), "a_rand");
        run_q(0, build(1'b1, OP_LW, 6'h0, 0, 0, 1), "a_lw");
        run_q(0, build(1'b1, OP_SW, 6'h0, 0, 3, 1), "a_sw_wait");
        run_q(0, build(1'b1, OP_RTYPE, FUNCT_JR, 0, 0, 1), "a_jr");
        run_q(0, build(1'b1, OP_JAL, 6'h0, 2, 0, 1), "a_jal");
        // Stop inside the first MEMRD wait cycle and reset mid-access.
        q = build(1'b1, OP_LW, 6'h0, 0, 5, 1);
        for (int i = 0; i < 4; i++) apply(0, q[i], "a_pre_rst");
        #2 rst_a_n = 1'b0;
        #1 reset_check(0, "a_rst_async");
        @(negedge clk);
        #1 reset_check(0, "a_rst_hold");
        run_q(0, build(1'b1, opcode_type'(6'h3F), 6'h0, 0, 0, 20), "a_halt");
    endtask

    task automatic proc_b();
        rst_b_n         = 1'b0;
        bus_b.op        = OP_RTYPE;
        bus_b.funct     = 6'h0;
        bus_b.mem_ready = 1'b0;
        @(negedge clk);
        #1 reset_check(1, "b_reset");
        for (int n = 0; n < 80; n++)
            run_q(1, build(1'b0, pick_op(1'b1), pick_fn(), 0, 0, 1), "b_rand");
        run_q(1, build(1'b0, opcode_type'(6'h3F), 6'h0, 0, 0, 1), "b_illegal");
        run_q(1, build(1'b0, OP_J, 6'h0, 0, 0, 1), "b_after_illegal");
    endtask

    initial begin : main
        rec_q_t q;
        int     cnt;
        // Hand-derived latencies and control words that the model must reproduce.
        q = build(1'b1, OP_LW, 6'h0, 0, 0, 1);
        check("model lw length", 32'(q.size()), 32'd5);
        check("model lw state5", 32'(q[4].st), 32'(S_MEMWB));
        check("model lw wb", 32'({q[4].out.reg_write, q[4].out.mem_to_reg}), 32'h5);
        q = build(1'b1, OP_SW, 6'h0, 0, 3, 1);
        check("model sw wait length", 32'(q.size()), 32'd7);
        cnt = 0;
        foreach (q[i]) if (q[i].out.mem_write) cnt++;
        check("model sw mem_write cycles", 32'(cnt), 32'd4);
        q = build(1'b1, OP_JAL, 6'h0, 0, 0, 1);
        check("model jal length", 32'(q.size()), 32'd3);
        check("model jal word", 32'({q[2].out.reg_dst, q[2].out.mem_to_reg, q[2].out.reg_write,
                                     q[2].out.pc_write, q[2].out.pc_src}), 32'hAE);
        q = build(1'b1, OP_RTYPE, FUNCT_JR, 0, 0, 1);
        check("model jr state", 32'(q[2].st), 32'(S_JR));
        check("model jr pc_src", 32'(q[2].out.pc_src), 32'd3);
        fork
            proc_a();
            proc_b();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects. It supports a wait-state memory handshake and a wider instruction set (SLTI, XORI, JAL, JR), and traps illegal opcodes. It sits between the instruction register/opcode field and the shared multi-cycle datapath (PC, IR, ALU, register file, unified memory).

Parameters:
ALUOP_W, 3, width of alu_op; encodings are package constants.
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored, every access takes 1 cycle.
HALT_ON_ILLEGAL, 1, 1 = ILLEGAL state is sticky until reset; 0 = ILLEGAL returns to FETCH after 1 cycle.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  opcode_type  opcode field of IR (types package)
funct  in  6  funct field of IR; used only for the JR decode
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC load
pc_write_beq  out  1  PC load if ALU zero
pc_write_bne  out  1  PC load if ALU not zero
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  2  write-register select: 0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
alu_op  out  ALUOP_W  ADD, SUB, FUNCT, SLT, XOR
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (JR)
illegal  out  1  high while in ILLEGAL
state_o  out  ctrl_state_t  current state, for debug

Behaviour:
- Reset: async assertion forces FETCH. Every enable/request output is 0 in reset. Selects are 0. illegal = 0.
- Outputs are Moore and decoded from state only. Exception: enables that are gated by mem_ready are noted below. In every state, anything not listed is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. ir_write and pc_write are asserted only in the cycle mem_ready=1 (always when MEM_WAIT_EN=0). The state holds while mem_ready=0, otherwise goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Next state by op: LW/SW→MEMADR; RTYPE→JR if funct==6'h08, else RTEXEC; ADDI/SLTI/XORI→IEXEC; BEQ→BEQ; BNE→BNE; J→JUMP; JAL→JAL; anything else→ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=ADD. LW→MEMRD, SW→MEMWR.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then →MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 →FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready, then →FETCH. mem_write stays asserted for the whole wait.
- RTEXEC: alu_src_a=1, alu_src_b=0, alu_op=FUNCT →RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 →FETCH.
- IEXEC: alu_src_a=1, alu_src_b=2. alu_op is ADD for ADDI, SLT for SLTI, XOR for XORI. op is latched at DECODE into an internal register, so this stays valid even if the IR changes. →IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 →FETCH.
- BEQ / BNE: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1. pc_write_beq or pc_write_bne respectively. →FETCH.
- JUMP: pc_write=1, pc_src=2 →FETCH.
- JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already equals PC+4) →FETCH.
- JR: pc_write=1, pc_src=3 →FETCH.
- ILLEGAL: illegal=1. Sticky if HALT_ON_ILLEGAL=1, else →FETCH.
- Latency in cycles with zero wait: LW 5, SW 4, R-type/I-ALU 4, branch/jump/JAL/JR 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.
- Reset mid-access: requests drop immediately (async). No partial register write can occur because writes happen only in writeback states.

Decomposition:
- types package:
  - opcode_type extended with OP_SLTI, OP_XORI, OP_JAL.
  - FUNCT_JR constant.
  - ctrl_state_t enum.
  - ALU op constants ALU_ADD/SUB/FUNCT/SLT/XOR.
  - Mux select constants for reg_dst, mem_to_reg, alu_src_b, pc_src.
- Sub-module: ctrl_output_decode, a pure combinational map from state (plus latched op and mem_ready) to outputs. The top level holds only state and op registers and the next-state logic.

Test Plan:
- Reset while in MEMRD with mem_read=1 → next sample shows state_o=FETCH, all enables 0.
- LW with mem_ready tied 1 → 5 cycles. Sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 only in cycle 5.
- SW with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 consecutive cycles, then FETCH, 7 cycles total.
- RTYPE funct=6'h08 → DECODE→JR, pc_src=3, pc_write=1, reg_write never asserted.
- JAL → 3 cycles. In cycle 3: reg_dst=2, mem_to_reg=2, reg_write=1, pc_write=1, pc_src=2.
- op=6'h3F with HALT_ON_ILLEGAL=1 → illegal=1 and state stays ILLEGAL for 20 cycles. With HALT_ON_ILLEGAL=0 → illegal high 1 cycle, then FETCH.
